// File: rtl/alu_axil_seq_core_if.sv
// AXI4-Lite slave bundle for the ALU core.
// Signal names follow the AXI channel names used at the top level.
interface alu_axil_seq_core_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic [AW-1:0]   S_AXI_AWADDR;
   logic [2:0]      S_AXI_AWPROT;
   logic            S_AXI_AWVALID;
   logic            S_AXI_AWREADY;
   logic [DW-1:0]   S_AXI_WDATA;
   logic [DW/8-1:0] S_AXI_WSTRB;
   logic            S_AXI_WVALID;
   logic            S_AXI_WREADY;
   logic [1:0]      S_AXI_BRESP;
   logic            S_AXI_BVALID;
   logic            S_AXI_BREADY;
   logic [AW-1:0]   S_AXI_ARADDR;
   logic [2:0]      S_AXI_ARPROT;
   logic            S_AXI_ARVALID;
   logic            S_AXI_ARREADY;
   logic [DW-1:0]   S_AXI_RDATA;
   logic [1:0]      S_AXI_RRESP;
   logic            S_AXI_RVALID;
   logic            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/alu_axil_seq_core.sv
// AXI4-Lite ALU: single-cycle logic/arith ops, shift-add MUL and restoring DIV.
//  state | meaning
//  IDLE  | waiting for START; results and flags stable
//  EXEC  | operation running on snapshotted operands
module alu_axil_seq_core #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_VERSION = 32'h0002_0000
) (
   input  logic               ACLK,
   input  logic               ARESET,
   alu_axil_seq_core_if.slave s_axi,
   output logic               irq
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_MUL = 4'd7,
                          OP_DIV = 4'd8;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state_q, state_d;
   logic [3:0]    op_q, op_d, op_s_q, op_s_d;
   logic          irq_en_q, irq_en_d;
   logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [DW-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic [DW-1:0] acc_q, acc_d, shf_q, shf_d, b_s_q, b_s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d, divz_q, divz_d, carry_q, carry_d, illegal_q, illegal_d;
   logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          busy, wr_hs, rd_hs, start_req, div_ge;
   logic [2:0]    waddr, raddr;
   logic [DW-1:0] ctrl_wr, rd_mux, div_acc, div_shf;
   logic [DW:0]   sum, diff, mul_sum, div_trial, div_sub;
   logic          unused_bits;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] data,
                                           input logic [DW/8-1:0] strb);
      logic [DW-1:0] r;
      r = old_v;
      for (int i = 0; i < DW/8; i++)
         if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

   assign busy      = (state_q == EXEC);
   assign wr_hs     = !ARESET && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q;
   assign rd_hs     = !ARESET && s_axi.S_AXI_ARVALID && !rvalid_q;
   assign waddr     = s_axi.S_AXI_AWADDR[4:2];
   assign raddr     = s_axi.S_AXI_ARADDR[4:2];
   // START reads as 0, so the merged image carries it only when byte 1 is strobed
   assign ctrl_wr   = merge({{(DW-17){1'b0}}, irq_en_q, 12'b0, op_q},
                            s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
   assign start_req = wr_hs && (waddr == 3'd0) && ctrl_wr[8];

   assign sum       = {1'b0, shf_q} + {1'b0, b_s_q};
   assign diff      = {1'b0, shf_q} - {1'b0, b_s_q};
   assign mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, b_s_q} : '0);
   assign div_trial = {acc_q, shf_q[DW-1]};
   assign div_ge    = (div_trial >= {1'b0, b_s_q});
   assign div_sub   = div_trial - {1'b0, b_s_q};
   assign div_acc   = div_ge ? div_sub[DW-1:0] : div_trial[DW-1:0];
   assign div_shf   = {shf_q[DW-2:0], div_ge};

   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR,
                          s_axi.S_AXI_ARADDR, ctrl_wr, div_sub[DW]};

   always_comb begin
      rd_mux = '0;
      case (raddr)
         3'd0: rd_mux = {{(DW-17){1'b0}}, irq_en_q, 7'b0, 1'b0, 4'b0, op_q};
         3'd1: rd_mux = {{(DW-5){1'b0}}, illegal_q, carry_q, divz_q, done_q, busy};
         3'd2: rd_mux = opa_q;
         3'd3: rd_mux = opb_q;
         3'd4: rd_mux = res_lo_q;
         3'd5: rd_mux = res_hi_q;
         3'd6: rd_mux = C_VERSION;
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;   op_d      = op_q;      op_s_d   = op_s_q;
      irq_en_d  = irq_en_q;  opa_d     = opa_q;     opb_d    = opb_q;
      res_lo_d  = res_lo_q;  res_hi_d  = res_hi_q;
      acc_d     = acc_q;     shf_d     = shf_q;     b_s_d    = b_s_q;   cnt_d = cnt_q;
      done_d    = done_q;    divz_d    = divz_q;    carry_d  = carry_q; illegal_d = illegal_q;
      bvalid_d  = bvalid_q;  rvalid_d  = rvalid_q;  rdata_d  = rdata_q;

      if (wr_hs) begin
         bvalid_d = 1'b1;
         case (waddr)
            3'd0: begin op_d = ctrl_wr[3:0]; irq_en_d = ctrl_wr[16]; end
            3'd1: if (s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[1]) done_d = 1'b0;
            3'd2: opa_d = merge(opa_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
            3'd3: opb_d = merge(opb_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
            default: ;
         endcase
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      if (rd_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end

      // completion assignments come after the W1C so a hardware DONE set wins
      case (state_q)
         IDLE: if (start_req) begin
            state_d = EXEC;      op_s_d  = ctrl_wr[3:0];
            acc_d   = '0;        shf_d   = opa_q;   b_s_d = opb_q;   cnt_d = CNT_LOAD;
            done_d  = 1'b0;      divz_d  = 1'b0;    carry_d = 1'b0;  illegal_d = 1'b0;
         end
         EXEC: begin
            if (op_s_q == OP_MUL || (op_s_q == OP_DIV && b_s_q != '0)) begin
               acc_d = (op_s_q == OP_MUL) ? mul_sum[DW:1] : div_acc;
               shf_d = (op_s_q == OP_MUL) ? {mul_sum[0], shf_q[DW-1:1]} : div_shf;
               if (cnt_q == '0) begin
                  res_hi_d = acc_d;
                  res_lo_d = shf_d;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else begin
               res_hi_d = '0;
               done_d   = 1'b1;
               state_d  = IDLE;
               case (op_s_q)
                  OP_ADD: begin res_lo_d = sum[DW-1:0];  carry_d = sum[DW];  end
                  OP_SUB: begin res_lo_d = diff[DW-1:0]; carry_d = diff[DW]; end
                  OP_AND: res_lo_d = shf_q & b_s_q;
                  OP_OR:  res_lo_d = shf_q | b_s_q;
                  OP_XOR: res_lo_d = shf_q ^ b_s_q;
                  OP_SLL: res_lo_d = shf_q << b_s_q[CW-1:0];
                  OP_SRL: res_lo_d = shf_q >> b_s_q[CW-1:0];
                  OP_DIV: begin res_lo_d = '1; res_hi_d = shf_q; divz_d = 1'b1; end
                  default: begin res_lo_d = '0; illegal_d = 1'b1; end
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= IDLE; op_q    <= '0; op_s_q  <= '0; irq_en_q <= 1'b0;
         opa_q    <= '0;   opb_q   <= '0; res_lo_q <= '0; res_hi_q <= '0;
         acc_q    <= '0;   shf_q   <= '0; b_s_q   <= '0; cnt_q    <= '0;
         done_q   <= 1'b0; divz_q  <= 1'b0; carry_q <= 1'b0; illegal_q <= 1'b0;
         bvalid_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0;
      end else begin
         state_q  <= state_d;  op_q    <= op_d;    op_s_q  <= op_s_d;  irq_en_q <= irq_en_d;
         opa_q    <= opa_d;    opb_q   <= opb_d;   res_lo_q <= res_lo_d; res_hi_q <= res_hi_d;
         acc_q    <= acc_d;    shf_q   <= shf_d;   b_s_q   <= b_s_d;   cnt_q    <= cnt_d;
         done_q   <= done_d;   divz_q  <= divz_d;  carry_q <= carry_d; illegal_q <= illegal_d;
         bvalid_q <= bvalid_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d;
      end
   end

   assign s_axi.S_AXI_AWREADY = wr_hs;
   assign s_axi.S_AXI_WREADY  = wr_hs;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_ARREADY = rd_hs;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign irq                 = done_q & irq_en_q;
endmodule

// File: tb/tb_alu_axil_seq_core.sv
// Self-checking bench for alu_axil_seq_core: scoreboard of expected register reads.
module tb_alu_axil_seq_core;
   localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_OPA = 5'h08, A_OPB = 5'h0C,
                          A_LO = 5'h10, A_HI = 5'h14, A_VER = 5'h18, A_NONE = 5'h1C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;
   always #5 clk = ~clk;

   alu_axil_seq_core_if #(.DW(32), .AW(5)) bus();

   alu_axil_seq_core dut (
      .ACLK(clk),
      .ARESET(rst),
      .s_axi(bus),
      .irq(irq)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd, e, st;

   int   busy_cnt = 0;
   logic busy_clr = 1'b0;
   always @(negedge clk) begin
      if (busy_clr) busy_cnt <= 0;
      else if (dut.busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic clr_busy();
      busy_clr = 1'b1;
      @(posedge clk); #1;
      busy_clr = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic got;
      got = 1'b0;
      bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL write_accept addr=%h got=no_awready exp=awready", addr);
      end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_BVALID) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!got) begin
         checks++; failures++;
         $display("FAIL write_bresp addr=%h got=no_bvalid exp=bvalid", addr);
      end
   endtask

   task automatic do_read(input logic [4:0] addr, output logic [31:0] data);
      logic got;
      got = 1'b0;
      data = 'x;
      bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_ARREADY) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 20 && got; i++) begin
         @(negedge clk);
         if (bus.S_AXI_RVALID) begin data = bus.S_AXI_RDATA; break; end
      end
      @(posedge clk); #1;
      if (!got) begin
         checks++; failures++;
         $display("FAIL read_accept addr=%h got=no_arready exp=arready", addr);
      end
   endtask

   task automatic wait_done(output logic [31:0] s);
      logic got;
      got = 1'b0;
      s = '0;
      for (int i = 0; i < 60; i++) begin
         do_read(A_STATUS, s);
         if (s[1] && !s[0]) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin failures++; $display("FAIL wait_done got=%h exp=done_not_busy", s); end
   endtask

   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi, output logic [31:0] s);
      logic [32:0] t;
      logic [63:0] p;
      lo = '0; hi = '0; s = 32'h2;
      case (op)
         4'd0: begin t = {1'b0, a} + {1'b0, b}; lo = t[31:0]; if (t[32]) s |= 32'h8; end
         4'd1: begin lo = a - b; if (a < b) s |= 32'h8; end
         4'd2: lo = a & b;
         4'd3: lo = a | b;
         4'd4: lo = a ^ b;
         4'd5: lo = a << b[4:0];
         4'd6: lo = a >> b[4:0];
         4'd7: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; end
         4'd8: if (b == 0) begin lo = '1; hi = a; s |= 32'h4; end
               else begin lo = a / b; hi = a % b; end
         default: s |= 32'h10;
      endcase
   endfunction

   task automatic test_reset();
      logic [4:0] addrs [3];
      addrs = '{A_VER, A_STATUS, A_NONE};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({irq, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 5'b0
          || bus.S_AXI_RDATA !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h exp=0/0",
                  {irq, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY},
                  bus.S_AXI_RDATA);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(32'h0002_0000); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      for (int k = 0; k < 3; k++) begin
         do_read(addrs[k], rd);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin failures++; $display("FAIL reset_read%0d got=%h exp=%h", k, rd, e); end
      end
   endtask

   task automatic test_add();
      do_write(A_OPA, 32'hFFFF_FFFF, 4'hF);
      do_write(A_OPB, 32'h1, 4'hF);
      clr_busy();
      exp_q.push_back(32'hA); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      do_write(A_CTRL, 32'h100, 4'hF);
      wait_done(st);
      e = exp_q.pop_front(); checks++;
      if (st !== e) begin failures++; $display("FAIL add_status got=%h exp=%h", st, e); end
      do_read(A_LO, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL add_res_lo got=%h exp=%h", rd, e); end
      do_read(A_HI, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL add_res_hi got=%h exp=%h", rd, e); end
      checks++;
      if (busy_cnt != 1) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=1", busy_cnt); end
   endtask

   task automatic test_mul();
      do_write(A_OPA, 32'h1234_5678, 4'hF);
      do_write(A_OPB, 32'h0001_0000, 4'hF);
      clr_busy();
      exp_q.push_back(32'h5678_0000); exp_q.push_back(32'h0000_1234);
      do_write(A_CTRL, 32'h107, 4'hF);
      wait_done(st);
      checks++;
      if (busy_cnt != 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", busy_cnt); end
      do_read(A_LO, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL mul_res_lo got=%h exp=%h", rd, e); end
      do_read(A_HI, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL mul_res_hi got=%h exp=%h", rd, e); end
   endtask

   task automatic test_div();
      logic [31:0] bs [2];
      logic [31:0] lo, hi, s;
      bs = '{32'd7, 32'd0};
      for (int k = 0; k < 2; k++) begin
         model(4'd8, 32'd100, bs[k], lo, hi, s);
         exp_q.push_back(s); exp_q.push_back(lo); exp_q.push_back(hi);
         do_write(A_OPA, 32'd100, 4'hF);
         do_write(A_OPB, bs[k], 4'hF);
         clr_busy();
         do_write(A_CTRL, 32'h108, 4'hF);
         wait_done(st);
         e = exp_q.pop_front(); checks++;
         if (st !== e) begin failures++; $display("FAIL div%0d_status got=%h exp=%h", k, st, e); end
         do_read(A_LO, rd); e = exp_q.pop_front(); checks++;
         if (rd !== e) begin failures++; $display("FAIL div%0d_res_lo got=%h exp=%h", k, rd, e); end
         do_read(A_HI, rd); e = exp_q.pop_front(); checks++;
         if (rd !== e) begin failures++; $display("FAIL div%0d_res_hi got=%h exp=%h", k, rd, e); end
         checks++;
         if (busy_cnt != (k == 0 ? 32 : 1)) begin
            failures++;
            $display("FAIL div%0d_busy_cycles got=%0d exp=%0d", k, busy_cnt, (k == 0 ? 32 : 1));
         end
      end
   endtask

   task automatic test_irq_concurrency();
      do_write(A_OPA, 32'h1234_5678, 4'hF);
      do_write(A_OPB, 32'h0001_0000, 4'hF);
      clr_busy();
      exp_q.push_back(32'h5678_0000); exp_q.push_back(32'h0000_1234);
      exp_q.push_back(32'h0001_0000); exp_q.push_back(32'h5);
      do_write(A_CTRL, 32'h0001_0107, 4'hF);
      do_write(A_CTRL, 32'h0001_0100, 4'hF);
      do_write(A_OPA, 32'h5, 4'hF);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_during_busy got=%b exp=0", irq); end
      wait_done(st);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_at_done got=%b exp=1", irq); end
      checks++;
      if (busy_cnt != 32) begin failures++; $display("FAIL irq_busy_cycles got=%0d exp=32", busy_cnt); end
      do_read(A_LO, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL irq_res_lo got=%h exp=%h", rd, e); end
      do_read(A_HI, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL irq_res_hi got=%h exp=%h", rd, e); end
      do_read(A_CTRL, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL irq_ctrl got=%h exp=%h", rd, e); end
      do_read(A_OPA, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL irq_opa got=%h exp=%h", rd, e); end
      do_write(A_STATUS, 32'h2, 4'hF);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
      do_write(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_ops();
      logic [3:0]  ops [11];
      logic [31:0] a, b, lo, hi, s;
      ops = '{4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd8, 4'd7};
      for (int k = 0; k < 11; k++) begin
         a = $urandom;
         b = (k == 9) ? 32'h0 : ((ops[k] == 4'd8) ? $urandom_range(1, 32'h0000_FFFF) : $urandom);
         model(ops[k], a, b, lo, hi, s);
         exp_q.push_back(s); exp_q.push_back(lo); exp_q.push_back(hi);
         do_write(A_OPA, a, 4'hF);
         do_write(A_OPB, b, 4'hF);
         do_write(A_CTRL, 32'h100 | {28'b0, ops[k]}, 4'hF);
         wait_done(st);
         e = exp_q.pop_front(); checks++;
         if (st !== e) begin failures++; $display("FAIL op%0d_status got=%h exp=%h", ops[k], st, e); end
         do_read(A_LO, rd); e = exp_q.pop_front(); checks++;
         if (rd !== e) begin failures++; $display("FAIL op%0d_res_lo got=%h exp=%h", ops[k], rd, e); end
         do_read(A_HI, rd); e = exp_q.pop_front(); checks++;
         if (rd !== e) begin failures++; $display("FAIL op%0d_res_hi got=%h exp=%h", ops[k], rd, e); end
      end
   endtask

   task automatic test_bus_stall();
      logic ok_b, ok_aw, ok_r, ok_ar, got;
      logic [31:0] r0;
      do_write(A_OPB, 32'h1111_0000, 4'hF);
      do_write(A_OPA, 32'h0, 4'hF);
      do_write(A_OPA, 32'hA5A5_0001, 4'h3);
      exp_q.push_back(32'h0000_0001);
      do_read(A_OPA, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL wstrb_opa got=%h exp=%h", rd, e); end
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_AWADDR = A_OPA; bus.S_AXI_WDATA = 32'hA5A5_0001; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_AWREADY) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = A_OPB; bus.S_AXI_WDATA = 32'hDEAD_BEEF;
      ok_b = got; ok_aw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.S_AXI_BVALID) ok_b = 1'b0;
         if (bus.S_AXI_AWREADY) ok_aw = 1'b0;
      end
      checks++;
      if (!ok_b) begin failures++; $display("FAIL bvalid_hold got=dropped exp=held"); end
      checks++;
      if (!ok_aw) begin failures++; $display("FAIL aw_while_bvalid got=accepted exp=blocked"); end
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL bvalid_release got=%b exp=0", bus.S_AXI_BVALID); end
      exp_q.push_back(32'h1111_0000);
      do_read(A_OPB, rd); e = exp_q.pop_front(); checks++;
      if (rd !== e) begin failures++; $display("FAIL stall_opb got=%h exp=%h", rd, e); end

      exp_q.push_back(32'hA5A5_0001);
      bus.S_AXI_RREADY = 1'b0;
      bus.S_AXI_ARADDR = A_OPA; bus.S_AXI_ARVALID = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_ARREADY) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_ARADDR = A_VER;
      @(negedge clk);
      r0 = bus.S_AXI_RDATA;
      ok_r = got && bus.S_AXI_RVALID; ok_ar = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== r0) ok_r = 1'b0;
         if (bus.S_AXI_ARREADY) ok_ar = 1'b0;
      end
      bus.S_AXI_ARVALID = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (r0 !== e) begin failures++; $display("FAIL stall_rdata got=%h exp=%h", r0, e); end
      checks++;
      if (!ok_r) begin failures++; $display("FAIL rvalid_hold got=changed exp=stable"); end
      checks++;
      if (!ok_ar) begin failures++; $display("FAIL ar_while_rvalid got=accepted exp=blocked"); end
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      logic [4:0] addrs [4];
      addrs = '{A_STATUS, A_LO, A_HI, A_OPA};
      do_write(A_OPA, 32'd100, 4'hF);
      do_write(A_OPB, 32'd7, 4'hF);
      do_write(A_CTRL, 32'h0001_0108, 4'hF);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut.busy !== 1'b0 || irq !== 1'b0) begin
         failures++; $display("FAIL reset_abort got=busy%b_irq%b exp=0_0", dut.busy, irq);
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
      for (int k = 0; k < 4; k++) begin
         do_read(addrs[k], rd);
         e = exp_q.pop_front(); checks++;
         if (rd !== e) begin failures++; $display("FAIL reset_mid_read%0d got=%h exp=%h", k, rd, e); end
      end
   endtask

   initial begin
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      test_reset();
      test_add();
      test_mul();
      test_div();
      test_irq_concurrency();
      test_ops();
      test_bus_stall();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
